// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        IDLE       = 1'b0,
        LOAD_STALL = 1'b1
    } hazard_state_e;

    localparam int REG_ZERO   = 0;
    localparam int BRANCH_ID  = 0;
    localparam int BRANCH_EXE = 1;

endpackage

// File: rtl/hazard_match.sv
// Load-use compare: the load in EXE writes a register the ID instruction reads.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic             mem_read,
    input  logic [REG_W-1:0] rt_reg,
    output logic             hit
);

    logic dest_nonzero;

    // $0 is hard-wired, so a load targeting it can never create a dependency
    assign dest_nonzero = (rt_reg != REG_W'(REG_ZERO));
    assign hit = mem_read & dest_nonzero &
                 ((uses_rs & (rs == rt_reg)) | (uses_rt & (rt == rt_reg)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory freeze
// and a saturating stall-cycle counter. Outputs are Mealy on state + inputs.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | no bubble in progress; a load-use hit stalls immediately
//   LOAD_STALL | extra bubbles for LOAD_LAT>1, cnt counts down to 1
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_STAGE = 0,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  IF_ID_Rs,
    input  logic [REG_W-1:0]  IF_ID_Rt,
    input  logic              IF_ID_UsesRs,
    input  logic              IF_ID_UsesRt,
    input  logic              ID_EXE_MemRead,
    input  logic [REG_W-1:0]  ID_EXE_RtReg,
    input  logic              Branch_Taken,
    input  logic              Mem_Busy,
    output logic              Stall,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EXE_Flush,
    output logic              Freeze,
    output logic [STAT_W-1:0] Stall_Count
);

    localparam logic        BRANCH_IN_EXE = (BRANCH_STAGE == BRANCH_EXE);
    localparam logic [2:0]  CNT_LOAD      = 3'(LOAD_LAT - 1);

    hazard_state_e state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          hit;

    hazard_match #(.REG_W(REG_W)) u_match (
        .rs       (IF_ID_Rs),
        .rt       (IF_ID_Rt),
        .uses_rs  (IF_ID_UsesRs),
        .uses_rt  (IF_ID_UsesRt),
        .mem_read (ID_EXE_MemRead),
        .rt_reg   (ID_EXE_RtReg),
        .hit      (hit)
    );

    always_comb begin
        Stall        = 1'b0;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EXE_Flush = 1'b0;
        Freeze       = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (reset) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (Mem_Busy) begin
            Freeze      = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (BRANCH_IN_EXE && Branch_Taken) begin
            // the ID instruction is wrong-path, so any pending bubble is moot
            IF_ID_Flush  = 1'b1;
            ID_EXE_Flush = 1'b1;
            state_d      = IDLE;
            cnt_d        = '0;
        end else if (state_q == LOAD_STALL) begin
            Stall       = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            cnt_d       = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = IDLE;
            end
        end else if (hit) begin
            Stall       = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            if (LOAD_LAT > 1) begin
                state_d = LOAD_STALL;
                cnt_d   = CNT_LOAD;
            end
        end else if (Branch_Taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EXE_Flush = BRANCH_IN_EXE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            Stall_Count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (Stall && (Stall_Count != {STAT_W{1'b1}})) begin
                Stall_Count <= Stall_Count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit across four parameter sets sharing one input bus.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs, rt, rtreg;
    logic       urs, urt, mr, bt, mb;

    int nchk = 0;
    int nerr = 0;

    // a: LOAD_LAT=1 BRANCH_STAGE=0; b: LOAD_LAT=3 ID; c: LOAD_LAT=3 EXE; d: LOAD_LAT=1 STAT_W=4
    logic        a_stall, a_pcw, a_ifw, a_iff, a_exf, a_frz;
    logic [15:0] a_cnt;
    logic        b_stall, b_pcw, b_ifw, b_iff, b_exf, b_frz;
    logic [15:0] b_cnt;
    logic        c_stall, c_pcw, c_ifw, c_iff, c_exf, c_frz;
    logic [15:0] c_cnt;
    logic        d_stall, d_pcw, d_ifw, d_iff, d_exf, d_frz;
    logic [3:0]  d_cnt;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .BRANCH_STAGE(0), .STAT_W(16)) u_a (
        .clk(clk), .reset(reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRs(urs),
        .IF_ID_UsesRt(urt), .ID_EXE_MemRead(mr), .ID_EXE_RtReg(rtreg), .Branch_Taken(bt),
        .Mem_Busy(mb), .Stall(a_stall), .PC_Write(a_pcw), .IF_ID_Write(a_ifw),
        .IF_ID_Flush(a_iff), .ID_EXE_Flush(a_exf), .Freeze(a_frz), .Stall_Count(a_cnt));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .BRANCH_STAGE(0), .STAT_W(16)) u_b (
        .clk(clk), .reset(reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRs(urs),
        .IF_ID_UsesRt(urt), .ID_EXE_MemRead(mr), .ID_EXE_RtReg(rtreg), .Branch_Taken(bt),
        .Mem_Busy(mb), .Stall(b_stall), .PC_Write(b_pcw), .IF_ID_Write(b_ifw),
        .IF_ID_Flush(b_iff), .ID_EXE_Flush(b_exf), .Freeze(b_frz), .Stall_Count(b_cnt));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .BRANCH_STAGE(1), .STAT_W(16)) u_c (
        .clk(clk), .reset(reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRs(urs),
        .IF_ID_UsesRt(urt), .ID_EXE_MemRead(mr), .ID_EXE_RtReg(rtreg), .Branch_Taken(bt),
        .Mem_Busy(mb), .Stall(c_stall), .PC_Write(c_pcw), .IF_ID_Write(c_ifw),
        .IF_ID_Flush(c_iff), .ID_EXE_Flush(c_exf), .Freeze(c_frz), .Stall_Count(c_cnt));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .BRANCH_STAGE(0), .STAT_W(4)) u_d (
        .clk(clk), .reset(reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRs(urs),
        .IF_ID_UsesRt(urt), .ID_EXE_MemRead(mr), .ID_EXE_RtReg(rtreg), .Branch_Taken(bt),
        .Mem_Busy(mb), .Stall(d_stall), .PC_Write(d_pcw), .IF_ID_Write(d_ifw),
        .IF_ID_Flush(d_iff), .ID_EXE_Flush(d_exf), .Freeze(d_frz), .Stall_Count(d_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs = 5'd0; rt = 5'd0; rtreg = 5'd0;
        urs = 1'b0; urt = 1'b0; mr = 1'b0; bt = 1'b0; mb = 1'b0;
    endtask

    task automatic set_hazard();
        rs = 5'd8; urs = 1'b1; mr = 1'b1; rtreg = 5'd8;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        set_hazard();
        reset = 1'b1;
        #1;
        nchk++;
        if ({b_stall, b_pcw, b_ifw, b_iff, b_exf, b_frz} !== 6'b011000) begin
            nerr++;
            $display("FAIL reset_outputs: got %b expected 011000",
                     {b_stall, b_pcw, b_ifw, b_iff, b_exf, b_frz});
        end
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        nchk++;
        if (b_cnt !== 16'd0 || b_stall !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: cnt=%0d stall=%b expected 0/0", b_cnt, b_stall);
        end
    endtask

    task automatic test_load_lat1();
        do_reset();
        set_hazard();
        #1;
        nchk++;
        if ({a_stall, a_pcw, a_ifw} !== 3'b100) begin
            nerr++;
            $display("FAIL lat1_stall: got %b expected 100", {a_stall, a_pcw, a_ifw});
        end
        tick();
        mr = 1'b0;
        #1;
        nchk++;
        if ({a_stall, a_pcw, a_ifw} !== 3'b011) begin
            nerr++;
            $display("FAIL lat1_release: got %b expected 011", {a_stall, a_pcw, a_ifw});
        end
        nchk++;
        if (a_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL lat1_count: got %0d expected 1", a_cnt);
        end
    endtask

    task automatic test_load_lat3();
        do_reset();
        set_hazard();
        for (int i = 0; i < 3; i++) begin
            #1;
            nchk++;
            if ({b_stall, b_pcw, b_ifw} !== 3'b100) begin
                nerr++;
                $display("FAIL lat3_bubble%0d: got %b expected 100", i, {b_stall, b_pcw, b_ifw});
            end
            tick();
            mr = 1'b0;
        end
        #1;
        nchk++;
        if ({b_stall, b_pcw, b_ifw} !== 3'b011) begin
            nerr++;
            $display("FAIL lat3_release: got %b expected 011", {b_stall, b_pcw, b_ifw});
        end
        nchk++;
        if (b_cnt !== 16'd3) begin
            nerr++;
            $display("FAIL lat3_count: got %0d expected 3", b_cnt);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        mr = 1'b1; rtreg = 5'd0; rs = 5'd0; urs = 1'b1;
        #1;
        nchk++;
        if (b_stall !== 1'b0) begin
            nerr++;
            $display("FAIL zero_reg: stall=%b expected 0", b_stall);
        end
        rtreg = 5'd9; rt = 5'd9; urt = 1'b0; rs = 5'd9; urs = 1'b0;
        #1;
        nchk++;
        if (b_stall !== 1'b0) begin
            nerr++;
            $display("FAIL unused_src: stall=%b expected 0", b_stall);
        end
        urt = 1'b1;
        #1;
        nchk++;
        if (b_stall !== 1'b1) begin
            nerr++;
            $display("FAIL rt_match: stall=%b expected 1", b_stall);
        end
    endtask

    task automatic test_mem_busy();
        do_reset();
        set_hazard();
        #1;
        nchk++;
        if (b_stall !== 1'b1) begin
            nerr++;
            $display("FAIL busy_first: stall=%b expected 1", b_stall);
        end
        tick();
        mr = 1'b0;
        #1;
        nchk++;
        if (b_stall !== 1'b1) begin
            nerr++;
            $display("FAIL busy_second: stall=%b expected 1", b_stall);
        end
        tick();
        mb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nchk++;
            if ({b_frz, b_stall, b_pcw, b_ifw, b_iff, b_exf} !== 6'b100000) begin
                nerr++;
                $display("FAIL busy_freeze%0d: got %b expected 100000", i,
                         {b_frz, b_stall, b_pcw, b_ifw, b_iff, b_exf});
            end
            tick();
        end
        nchk++;
        if (b_cnt !== 16'd2) begin
            nerr++;
            $display("FAIL busy_count_hold: got %0d expected 2", b_cnt);
        end
        mb = 1'b0;
        #1;
        nchk++;
        if (b_stall !== 1'b1) begin
            nerr++;
            $display("FAIL busy_third: stall=%b expected 1", b_stall);
        end
        tick();
        #1;
        nchk++;
        if (b_stall !== 1'b0 || b_cnt !== 16'd3) begin
            nerr++;
            $display("FAIL busy_done: stall=%b cnt=%0d expected 0/3", b_stall, b_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_hazard();
        bt = 1'b1;
        #1;
        nchk++;
        if ({c_stall, c_pcw, c_iff, c_exf} !== 4'b0111) begin
            nerr++;
            $display("FAIL exe_branch_beats_hit: got %b expected 0111",
                     {c_stall, c_pcw, c_iff, c_exf});
        end
        nchk++;
        if ({b_stall, b_iff, b_exf} !== 3'b100) begin
            nerr++;
            $display("FAIL id_hit_beats_branch: got %b expected 100", {b_stall, b_iff, b_exf});
        end
        tick();
        clear_inputs();
        #1;
        nchk++;
        if (c_stall !== 1'b0 || b_stall !== 1'b1) begin
            nerr++;
            $display("FAIL branch_next: exe_stall=%b id_stall=%b expected 0/1", c_stall, b_stall);
        end

        do_reset();
        set_hazard();
        tick();
        mr = 1'b0; bt = 1'b1;
        #1;
        nchk++;
        if ({c_stall, c_iff, c_exf} !== 3'b011) begin
            nerr++;
            $display("FAIL exe_abort_stall: got %b expected 011", {c_stall, c_iff, c_exf});
        end
        nchk++;
        if ({b_stall, b_iff, b_exf} !== 3'b100) begin
            nerr++;
            $display("FAIL id_branch_ignored: got %b expected 100", {b_stall, b_iff, b_exf});
        end
        tick();
        bt = 1'b0;
        #1;
        nchk++;
        if (c_stall !== 1'b0) begin
            nerr++;
            $display("FAIL exe_abort_idle: stall=%b expected 0", c_stall);
        end

        do_reset();
        bt = 1'b1;
        #1;
        nchk++;
        if ({b_stall, b_pcw, b_ifw, b_iff, b_exf} !== 5'b01110) begin
            nerr++;
            $display("FAIL id_branch_flush: got %b expected 01110",
                     {b_stall, b_pcw, b_ifw, b_iff, b_exf});
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_hazard();
        tick();
        mr = 1'b0;
        reset = 1'b1;
        #1;
        nchk++;
        if ({b_stall, b_pcw, b_ifw} !== 3'b011) begin
            nerr++;
            $display("FAIL reset_mid_forced: got %b expected 011", {b_stall, b_pcw, b_ifw});
        end
        tick();
        reset = 1'b0;
        #1;
        nchk++;
        if (b_stall !== 1'b0 || b_cnt !== 16'd0) begin
            nerr++;
            $display("FAIL reset_mid_after: stall=%b cnt=%0d expected 0/0", b_stall, b_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        set_hazard();
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        clear_inputs();
        #1;
        nchk++;
        if (d_cnt !== 4'd15) begin
            nerr++;
            $display("FAIL sat_count: got %0d expected 15", d_cnt);
        end
        nchk++;
        if (a_cnt !== 16'd20) begin
            nerr++;
            $display("FAIL wide_count: got %0d expected 20", a_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_load_lat1();
        test_load_lat3();
        test_no_hazard();
        test_mem_busy();
        test_branch();
        test_reset_mid_stall();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
